// File: rtl/analogizer_video_out_if.sv
// Video bus between the emu video outputs and the Analogizer SNAC pin packer.
//  in_rgb     {R[7:0],G[7:0],B[7:0]} pixel data, clk_vid domain
//  in_hs      horizontal sync, active-high
//  in_vs      vertical sync, active-high
//  in_de      data enable, 1 = active pixel
//  bank3_out  {R[7:2], hs_pin, vs_pin}
//  bank2_out  {B[2], de_pin, G[7:2]}
//  bank1_out  {B[7:3]}
// master: video source side; slave: the pin packer.
interface analogizer_video_out_if;
  logic [23:0] in_rgb;
  logic        in_hs;
  logic        in_vs;
  logic        in_de;
  logic [7:0]  bank3_out;
  logic [7:0]  bank2_out;
  logic [4:0]  bank1_out;

  modport master (
    output in_rgb, in_hs, in_vs, in_de,
    input  bank3_out, bank2_out, bank1_out
  );

  modport slave (
    input  in_rgb, in_hs, in_vs, in_de,
    output bank3_out, bank2_out, bank1_out
  );
endinterface

// File: rtl/analogizer_video_out.sv
// Registers the emu RGB888/HS/VS/DE stream and packs RGB666, sync and DE onto the three SNAC
// cart-bank buses feeding the Analogizer RGB DAC. Measures line length and HS width and builds
// composite sync (OR, XOR or serrated) for RGBS monitors. bank1[5] (video clock) is driven elsewhere.
//  clk_vid     pixel clock
//  reset_l     asynchronous active-low reset
//  vid         video bus (slave): in_rgb/in_hs/in_vs/in_de in, bank3/bank2/bank1 out
//  csync_mode  0 separate H/V, 1 OR, 2 XOR, 3 serrated (falls back to XOR when unlocked)
//  blank_en    force RGB to 0 while in_de = 0
//  line_len    last accepted line length in clocks
//  locked      two consecutive equal line lengths seen
module analogizer_video_out #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned MIN_LINE     = 256,
  parameter bit          OUT_SYNC_LOW = 1'b1
) (
  input  logic                       clk_vid,
  input  logic                       reset_l,
  analogizer_video_out_if.slave      vid,
  input  logic [1:0]                 csync_mode,
  input  logic                       blank_en,
  output logic [CNT_W-1:0]           line_len,
  output logic                       locked
);

  logic             r_hs_d;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] r_line_len;
  logic             r_locked;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_hs_width;
  logic             r_hs_acc;
  logic [CNT_W-1:0] r_scnt;
  logic [7:0]       r_bank3;
  logic [7:0]       r_bank2;
  logic [4:0]       r_bank1;

  logic             w_hs_rise;
  logic             w_hs_fall;
  logic             w_lcnt_sat;
  logic [CNT_W-1:0] w_lcnt_inc;
  logic             w_accept;
  logic             w_half;
  logic             w_pulse_start;
  logic [CNT_W-1:0] w_scnt_now;
  logic             w_serr_low;
  logic             w_hs_val;
  logic             w_vs_val;
  logic [23:0]      w_rgb;
  logic             w_unused_rgb;

  assign w_hs_rise  = vid.in_hs & ~r_hs_d;
  assign w_hs_fall  = ~vid.in_hs & r_hs_d;
  assign w_lcnt_sat = &r_lcnt;
  assign w_lcnt_inc = w_lcnt_sat ? r_lcnt : r_lcnt + 1'b1;
  // Rises closer together than MIN_LINE are glitches: the line keeps counting.
  assign w_accept   = w_hs_rise & (32'(w_lcnt_inc) >= MIN_LINE);
  assign w_half     = (r_lcnt == (r_line_len >> 1));

  // Serration pulse: a start (re)loads hs_width; low while the count is non-zero, so
  // overlapping pulses merge and the later one decides the end.
  assign w_pulse_start = w_accept | w_half;
  assign w_scnt_now    = w_pulse_start ? r_hs_width : r_scnt;
  assign w_serr_low    = (w_scnt_now != '0);

  always_comb begin
    w_hs_val = 1'b0;
    w_vs_val = 1'b0;
    unique case (csync_mode)
      2'd0: begin
        w_hs_val = vid.in_hs;
        w_vs_val = vid.in_vs;
      end
      2'd1: w_hs_val = vid.in_hs | vid.in_vs;
      2'd2: w_hs_val = vid.in_hs ^ vid.in_vs;
      2'd3: begin
        if (!r_locked)       w_hs_val = vid.in_hs ^ vid.in_vs;
        else if (!vid.in_vs) w_hs_val = vid.in_hs;
        else                 w_hs_val = ~w_serr_low;
      end
      default: ;
    endcase
  end

  assign w_rgb        = (blank_en && !vid.in_de) ? 24'h0 : vid.in_rgb;
  assign w_unused_rgb = ^{w_rgb[17:16], w_rgb[9:8], w_rgb[1:0]};

  always_ff @(posedge clk_vid or negedge reset_l) begin
    if (!reset_l) begin
      r_hs_d     <= 1'b0;
      r_lcnt     <= '0;
      r_line_len <= '0;
      r_locked   <= 1'b0;
      r_wcnt     <= '0;
      r_hs_width <= '0;
      r_hs_acc   <= 1'b0;
      r_scnt     <= '0;
      r_bank3    <= {6'b0, OUT_SYNC_LOW, OUT_SYNC_LOW};
      r_bank2    <= '0;
      r_bank1    <= '0;
    end else begin
      r_hs_d <= vid.in_hs;
      r_lcnt <= w_accept ? '0 : w_lcnt_inc;

      if (w_accept) begin
        r_line_len <= w_lcnt_inc;
        r_locked   <= (w_lcnt_inc == r_line_len);
      end else if (w_lcnt_sat) begin
        // HS lost: drop lock but keep the last good length.
        r_locked <= 1'b0;
      end

      // The rise clock itself is the first high clock, so the count restarts at 1.
      if (w_accept) begin
        r_wcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (vid.in_hs && !(&r_wcnt)) begin
        r_wcnt <= r_wcnt + 1'b1;
      end

      // Only the width of an accepted HS pulse is kept; glitch pulses are not measured.
      if (w_accept) begin
        r_hs_acc <= 1'b1;
      end else if (w_hs_fall) begin
        r_hs_acc <= 1'b0;
      end
      if (w_hs_fall && r_hs_acc) begin
        r_hs_width <= r_wcnt;
      end

      r_scnt <= w_serr_low ? w_scnt_now - 1'b1 : '0;

      r_bank3 <= {w_rgb[23:18], w_hs_val ^ OUT_SYNC_LOW, w_vs_val ^ OUT_SYNC_LOW};
      r_bank2 <= {w_rgb[2], vid.in_de, w_rgb[15:10]};
      r_bank1 <= w_rgb[7:3];
    end
  end

  assign vid.bank3_out = r_bank3;
  assign vid.bank2_out = r_bank2;
  assign vid.bank1_out = r_bank1;
  assign line_len      = r_line_len;
  assign locked        = r_locked;

endmodule

// File: tb/tb_analogizer_video_out.sv
module tb_analogizer_video_out;

  localparam int SAT = 4095;
  localparam int MIN_LINE = 256;

  typedef struct packed {
    logic [7:0]  b3;
    logic [7:0]  b2;
    logic [4:0]  b1;
    logic [11:0] len;
    logic        lck;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [1:0]  csync_mode = 2'd0;
  logic        blank_en = 1'b0;
  logic [11:0] line_len;
  logic        locked;

  analogizer_video_out_if vif();

  analogizer_video_out #(
    .CNT_W        (12),
    .MIN_LINE     (256),
    .OUT_SYNC_LOW (1'b1)
  ) dut (
    .clk_vid    (clk),
    .reset_l    (reset_l),
    .vid        (vif),
    .csync_mode (csync_mode),
    .blank_en   (blank_en),
    .line_len   (line_len),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Stimulus-side settings, applied together with the next pixel.
  logic [1:0] t_mode = 2'd0;
  bit         t_blank = 1'b0;

  // Reference model state, expressed in absolute drive-cycle numbers.
  int cyc = 0;          // index of the pixel being driven
  int base = 0;         // cycle at which the line counter reads 0
  int m_line_len = 0;
  bit m_locked = 0;
  int m_hs_width = 0;
  int m_rise_cyc = 0;
  bit m_acc = 0;
  int low_until = 0;    // serration output low while cyc < low_until
  bit m_hs_prev = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every output cycle is compared with the next queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({vif.bank3_out, vif.bank2_out, vif.bank1_out} !== {e.b3, e.b2, e.b1}) begin
        errors++;
        $display("FAIL pins cyc=%0d: got b3=%h b2=%h b1=%h want b3=%h b2=%h b1=%h", e.cyc,
                 vif.bank3_out, vif.bank2_out, vif.bank1_out, e.b3, e.b2, e.b1);
      end
      checks++;
      if ({line_len, locked} !== {e.len, e.lck}) begin
        errors++;
        $display("FAIL status cyc=%0d: got len=%0d lock=%0b want len=%0d lock=%0b", e.cyc,
                 line_len, locked, e.len, e.lck);
      end
    end
  end

  task automatic drive(input bit hs, input bit vs, input bit de, input logic [23:0] rgb);
    exp_t        e;
    int          lcnt;
    int          inc;
    bit          rise;
    bit          fall;
    bit          accept;
    bit          serr_low;
    bit          cs_h;
    bit          cs_v;
    logic [23:0] prgb;
    @(negedge clk);
    reset_l     = 1'b1;
    csync_mode  = t_mode;
    blank_en    = t_blank;
    vif.in_hs   = hs;
    vif.in_vs   = vs;
    vif.in_de   = de;
    vif.in_rgb  = rgb;

    lcnt   = imin(cyc - base, SAT);
    inc    = imin(lcnt + 1, SAT);
    rise   = hs && !m_hs_prev;
    fall   = !hs && m_hs_prev;
    accept = rise && (inc >= MIN_LINE);
    if (accept || lcnt == (m_line_len / 2)) low_until = cyc + m_hs_width;
    serr_low = (cyc < low_until);

    cs_v = 1'b0;
    case (t_mode)
      2'd0: begin cs_h = hs; cs_v = vs; end
      2'd1: cs_h = hs | vs;
      2'd2: cs_h = hs ^ vs;
      default: cs_h = !m_locked ? (hs ^ vs) : (!vs ? hs : !serr_low);
    endcase
    prgb = (t_blank && !de) ? 24'h0 : rgb;
    e.b3 = {prgb[23:18], ~cs_h, ~cs_v};
    e.b2 = {prgb[2], de, prgb[15:10]};
    e.b1 = prgb[7:3];

    if (accept) begin
      m_locked   = (inc == m_line_len);
      m_line_len = inc;
      base       = cyc + 1;
      m_rise_cyc = cyc;
      m_acc      = 1'b1;
    end else if (lcnt == SAT) begin
      m_locked = 1'b0;
    end
    if (fall && m_acc) begin
      m_hs_width = cyc - m_rise_cyc;
      m_acc      = 1'b0;
    end
    m_hs_prev = hs;

    e.len = m_line_len[11:0];
    e.lck = m_locked;
    e.cyc = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic do_reset(input int ncyc);
    exp_t e;
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("reset bank3", 64'(vif.bank3_out), 64'h03);
    check("reset bank2", 64'(vif.bank2_out), 64'h00);
    check("reset bank1", 64'(vif.bank1_out), 64'h00);
    check("reset line_len", 64'(line_len), 64'd0);
    check("reset locked", 64'(locked), 64'd0);
    m_line_len = 0; m_locked = 0; m_hs_width = 0; m_acc = 0;
    low_until = 0; m_hs_prev = 0; base = cyc;
    e = '{b3: 8'h03, b2: 8'h00, b1: 5'h00, len: 12'd0, lck: 1'b0, cyc: -1};
    exp_q.push_back(e);
    for (int i = 1; i < ncyc; i++) begin
      @(negedge clk);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_line(input int len, input int hsw, input bit vs, input int glitch_at,
                          input bit white);
    bit hs;
    for (int p = 0; p < len; p++) begin
      hs = (p < hsw) || (glitch_at >= 0 && p >= glitch_at && p < glitch_at + 10);
      drive(hs, vs, (p >= hsw + 8) && (p < len - 8), white ? 24'hFFFFFF : 24'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vif.in_rgb = '0; vif.in_hs = 1'b0; vif.in_vs = 1'b0; vif.in_de = 1'b0;
    do_reset(3);

    // Mode 0, 800-clock lines, 64-clock HS.
    t_mode = 2'd0;
    repeat (5) run_line(800, 64, 1'b0, -1, 1'b0);
    check("t1 line_len", 64'(line_len), 64'd800);
    check("t1 locked", 64'(locked), 64'd1);

    // Mode 2 with VS high for 3 lines, then OR mode.
    t_mode = 2'd2;
    repeat (3) run_line(800, 64, 1'b1, -1, 1'b0);
    t_mode = 2'd1;
    run_line(800, 64, 1'b1, -1, 1'b0);
    run_line(800, 64, 1'b0, -1, 1'b0);

    // Mode 3 serration while locked, then VS falls.
    t_mode = 2'd3;
    repeat (3) run_line(800, 64, 1'b1, -1, 1'b0);
    repeat (2) run_line(800, 64, 1'b0, -1, 1'b0);

    // Short glitch pulse inside a line must be ignored.
    run_line(800, 64, 1'b0, 150, 1'b0);
    run_line(800, 64, 1'b1, 150, 1'b0);
    run_line(800, 64, 1'b0, -1, 1'b0);
    check("t4 line_len", 64'(line_len), 64'd800);
    check("t4 locked", 64'(locked), 64'd1);

    // HS lost long enough to saturate; VS toggles so the XOR fallback is exercised.
    for (int p = 0; p < 4200; p++) begin
      drive(p < 64, ((p / 37) % 2) == 1, 1'b0, 24'($urandom));
    end
    check("t5 locked", 64'(locked), 64'd0);
    check("t5 line_len", 64'(line_len), 64'd800);
    repeat (3) run_line(800, 64, 1'b0, -1, 1'b0);

    // Wide HS against a short line: half-line pulses merge with the line pulses.
    repeat (4) run_line(300, 200, 1'b0, -1, 1'b0);
    repeat (2) run_line(300, 200, 1'b1, -1, 1'b0);

    // Randomized lines, modes, VS and blanking.
    for (int it = 0; it < 8; it++) begin
      int len;
      int hsw;
      bit vs;
      len     = $urandom_range(300, 900);
      hsw     = $urandom_range(1, 120);
      t_mode  = 2'($urandom_range(0, 3));
      t_blank = 1'($urandom_range(0, 1));
      for (int l = 0; l < 3; l++) begin
        vs = 1'($urandom_range(0, 1));
        run_line(len, hsw, vs, -1, 1'b0);
      end
    end

    // Blanking of white input outside DE, then reset mid-line.
    t_mode  = 2'd0;
    t_blank = 1'b1;
    run_line(800, 64, 1'b0, -1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    @(posedge clk);
    #2;
    check("t6 blank r", 64'(vif.bank3_out[7:2]), 64'd0);
    check("t6 blank g", 64'(vif.bank2_out[5:0]), 64'd0);
    check("t6 blank b", 64'(vif.bank1_out), 64'd0);
    check("t6 blank b2", 64'(vif.bank2_out[7]), 64'd0);
    run_line(400, 63, 1'b0, -1, 1'b1);
    do_reset(2);
    t_blank = 1'b0;
    repeat (4) run_line(800, 64, 1'b0, -1, 1'b0);
    check("t6 relock len", 64'(line_len), 64'd800);
    check("t6 relock", 64'(locked), 64'd1);

    @(negedge clk);
    @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
